// File: rtl/id_decode.sv
// rtl/id_decode.sv - RV32I decode stage with 2-entry skid buffer; optional ID_DECODE_ILLEGAL_EN opcode check
module id_decode #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [11:0]     imm_i_type,
    output logic [11:0]     imm_s_type,
    output logic [31:0]     imm_b_type,
    output logic [31:0]     imm_u_type,
    output logic [31:0]     imm_j_type,
    output logic            illegal
);

    logic [31:0]     m_instr;
    logic [PC_W-1:0] m_pc;
    logic            m_valid;
    logic [31:0]     s_instr;
    logic [PC_W-1:0] s_pc;
    logic            s_valid;
    logic            accept;
    logic            drain;

    // Ready depends only on registered state so there is no path from out_ready.
    assign in_ready = !s_valid;
    assign accept   = in_valid && in_ready;
    assign drain    = m_valid && out_ready;

    // Main register: refills from the skid entry first (it is older than the input).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_instr <= '0;
            m_pc    <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (!m_valid || drain) begin
            if (s_valid) begin
                m_instr <= s_instr;
                m_pc    <= s_pc;
                m_valid <= 1'b1;
            end else if (accept) begin
                m_instr <= in_instr;
                m_pc    <= in_pc;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Skid register: catches an accepted word while the main entry is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            s_instr <= '0;
            s_pc    <= '0;
        end else if (flush) begin
            s_valid <= 1'b0;
        end else if (s_valid) begin
            if (drain) begin
                s_valid <= 1'b0;
            end
        end else if (m_valid && !drain && accept) begin
            s_instr <= in_instr;
            s_pc    <= in_pc;
            s_valid <= 1'b1;
        end
    end

    assign out_valid  = m_valid;
    assign out_pc     = m_pc;
    assign opcode     = m_instr[6:0];
    assign rd         = m_instr[11:7];
    assign funct3     = m_instr[14:12];
    assign rs1        = m_instr[19:15];
    assign rs2        = m_instr[24:20];
    assign funct7     = m_instr[31:25];
    assign imm_i_type = m_instr[31:20];
    assign imm_s_type = {m_instr[31:25], m_instr[11:7]};
    assign imm_b_type = {{19{m_instr[31]}}, m_instr[31], m_instr[7], m_instr[30:25], m_instr[11:8], 1'b0};
    assign imm_u_type = {m_instr[31:12], 12'h000};
    assign imm_j_type = {{11{m_instr[31]}}, m_instr[31], m_instr[19:12], m_instr[20], m_instr[30:21], 1'b0};

`ifdef ID_DECODE_ILLEGAL_EN
    logic legal_op;

    // Every legal major opcode ends in 2'b11, so matching the full 7 bits also covers the low-bit check.
    always_comb begin
        legal_op = 1'b0;
        case (m_instr[6:0])
            7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h0F, 7'h73: legal_op = 1'b1;
            default:                           legal_op = 1'b0;
        endcase
    end

    assign illegal = m_valid && !legal_op;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_id_decode.sv
// tb/tb_id_decode.sv - randomized self-checking bench for id_decode against a queue model
module tb_id_decode;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    localparam logic [6:0] LEGAL_OPS [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                              7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
`ifdef ID_DECODE_ILLEGAL_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] imm_i_type;
    logic [11:0] imm_s_type;
    logic [31:0] imm_b_type;
    logic [31:0] imm_u_type;
    logic [31:0] imm_j_type;
    logic        illegal;

    int checks   = 0;
    int failures = 0;
    item_t q[$];

    id_decode #(.PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
        .imm_i_type(imm_i_type), .imm_s_type(imm_s_type), .imm_b_type(imm_b_type),
        .imm_u_type(imm_u_type), .imm_j_type(imm_j_type), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_illegal(input logic [31:0] i);
        logic bad;
        bad = 1'b1;
        for (int k = 0; k < 11; k++)
            if (i[6:0] == LEGAL_OPS[k]) bad = 1'b0;
        if (i[1:0] != 2'b11) bad = 1'b1;
        return bad && ILL_EN;
    endfunction

    // Reference: a FIFO of at most two instructions; the head is what decode presents.
    always @(posedge clk or negedge rst_n) begin : model
        bit acc;
        bit drn;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            drn = (q.size() > 0) && out_ready;
            if (drn) void'(q.pop_front());
            if (acc) q.push_back('{in_instr, in_pc});
        end
    end

    // Compare every cycle, away from the rising edge.
    always @(negedge clk) begin : compare
        item_t h;
        logic [31:0] i;
        chk("cmp_out_valid", out_valid, q.size() > 0);
        chk("cmp_in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            h = q[0];
            i = h.instr;
            chk("cmp_pc", out_pc, h.pc);
            chk("cmp_opcode", opcode, i & 32'h7F);
            chk("cmp_rd", rd, (i >> 7) & 32'h1F);
            chk("cmp_funct3", funct3, (i >> 12) & 32'h7);
            chk("cmp_rs1", rs1, (i >> 15) & 32'h1F);
            chk("cmp_rs2", rs2, (i >> 20) & 32'h1F);
            chk("cmp_funct7", funct7, i >> 25);
            chk("cmp_imm_i", imm_i_type, i >> 20);
            chk("cmp_imm_s", imm_s_type, ((i >> 25) << 5) | ((i >> 7) & 32'h1F));
            chk("cmp_imm_b", imm_b_type, 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})));
            chk("cmp_imm_u", imm_u_type, i & 32'hFFFFF000);
            chk("cmp_imm_j", imm_j_type, 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})));
            chk("cmp_illegal", illegal, exp_illegal(i));
        end
    end

    task automatic set_in(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                          input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        int sent;
        int ndrained;
        logic [31:0] drained [4];
        logic [31:0] r;

        rst_n = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_imm_j", imm_j_type, 0);
        chk("rst_illegal", illegal, 0);
        rst_n = 1'b1;

        // Single ADDI x1,x2,-1
        set_in(1'b1, 32'hFFF10093, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        chk("addi_valid", out_valid, 1);
        chk("addi_opcode", opcode, 7'h13);
        chk("addi_rd", rd, 1);
        chk("addi_funct3", funct3, 0);
        chk("addi_rs1", rs1, 2);
        chk("addi_imm_i", imm_i_type, 12'hFFF);
        chk("addi_illegal", illegal, 0);

        // Back-to-back B, U, J
        set_in(1'b1, 32'hFE000EE3, 32'h4, 1'b1, 1'b0);
        @(negedge clk);
        chk("b_valid", out_valid, 1);
        chk("b_imm", imm_b_type, 32'hFFFFFFFC);
        set_in(1'b1, 32'h123452B7, 32'h8, 1'b1, 1'b0);
        @(negedge clk);
        chk("u_valid", out_valid, 1);
        chk("u_imm", imm_u_type, 32'h12345000);
        chk("u_rd", rd, 5);
        set_in(1'b1, 32'h008000EF, 32'hC, 1'b1, 1'b0);
        @(negedge clk);
        chk("j_valid", out_valid, 1);
        chk("j_imm", imm_j_type, 32'h00000008);
        chk("j_rd", rd, 1);
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);

        // Backpressure: 4 instructions, out_ready low for 3 cycles
        sent = 0;
        ndrained = 0;
        for (int c = 0; c < 20 && ndrained < 4; c++) begin
            if (c == 2) chk("bp_in_ready_low", in_ready, 0);
            if (c >= 1 && c <= 3) chk("bp_hold_pc", out_pc, 32'h0);
            if (out_valid && c >= 3) begin
                drained[ndrained] = out_pc;
                ndrained++;
            end
            if (sent < 4) begin
                set_in(1'b1, 32'h00000013 | (32'(sent) << 7), 32'(sent * 4), c >= 3, 1'b0);
                if (in_ready) sent++;
            end else begin
                set_in(1'b0, 32'h0, 32'h0, c >= 3, 1'b0);
            end
            @(negedge clk);
        end
        chk("bp_drain_count", ndrained, 4);
        for (int k = 0; k < ndrained; k++) chk("bp_order", drained[k], 32'(k * 4));

        // Flush with both entries full and a simultaneous input
        set_in(1'b1, 32'h00100093, 32'h100, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b1, 32'h00200093, 32'h104, 1'b0, 1'b0);
        @(negedge clk);
        chk("fl_full", in_ready, 0);
        set_in(1'b1, 32'h00300093, 32'h108, 1'b0, 1'b1);
        @(negedge clk);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("fl_no_ghost", out_valid, 0);
        end

        // Illegal opcodes
        set_in(1'b1, 32'h00000000, 32'h200, 1'b1, 1'b0);
        @(negedge clk);
        chk("ill_zero", illegal, ILL_EN);
        set_in(1'b1, 32'h0000007F, 32'h204, 1'b1, 1'b0);
        @(negedge clk);
        chk("ill_7f", illegal, ILL_EN);
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);

        // Asynchronous reset while stalled
        set_in(1'b1, 32'hFFF10093, 32'h40, 1'b0, 1'b0);
        @(negedge clk);
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_in_ready", in_ready, 1);
        chk("ar_pc", out_pc, 0);
        chk("ar_opcode", opcode, 0);
        chk("ar_imm_i", imm_i_type, 0);
        chk("ar_imm_b", imm_b_type, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            r = $urandom;
            if ($urandom_range(0, 1) == 1) r[6:0] = LEGAL_OPS[$urandom_range(0, 10)];
            set_in($urandom_range(0, 3) != 0, r, $urandom, $urandom_range(0, 2) != 0,
                   $urandom_range(0, 31) == 0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
